iter_sequencer: RTL and testbench

//  Parametrised iteration controller for the power-iteration datapath. Runs a programmable number of

---
 rtl/iter_seq_pkg.sv | 20 ++
 rtl/iter_watchdog.sv | 37 +++
 rtl/iter_sequencer.sv | 174 +++++++++++++++++
 tb/tb_iter_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_seq_pkg.sv
// Shared state encoding, defaults and bank-rotation helper for the
// power-iteration sequencer.
package iter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam int ITER_DEFAULT = 30;
    localparam int GAP_W        = 8;

    // Non-power-of-two bank counts are legal, so wrap explicitly instead of relying on overflow.
    function automatic int unsigned bankInc(input int unsigned bank, input int unsigned numBanks);
        return (bank + 1 >= numBanks) ? 0 : bank + 1;
    endfunction

endpackage

// File: rtl/iter_watchdog.sv
// Saturating cycle counter that flags the cycle on which it would reach all-ones,
// giving the sequencer an expiry pulse while a pass is running.
module iter_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [TIMEOUT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the edge that saturates the count; a clear on the same edge suppresses it.
    assign expire_o = enable_i && !clear_i && (count_q == (CNT_MAX - TIMEOUT_W'(1)));

endmodule

// File: rtl/iter_sequencer.sv
// Iteration controller: runs N accumulate passes with bank rotation and idle gaps,
// exiting early on convergence, abort or watchdog timeout.
module iter_sequencer
    import iter_seq_pkg::*;
#(
    parameter int CNT_W         = 6,
    parameter int DEFAULT_ITERS = ITER_DEFAULT,
    parameter int GAP_CYCLES    = 1,
    parameter int NUM_BANKS     = 2,
    parameter int TIMEOUT_W     = 16,
    localparam int BANK_W       = $clog2(NUM_BANKS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_start,
    input  logic [CNT_W-1:0]  in_iters,
    input  logic              in_abort,
    input  logic              in_accumCalcDoneFlag,
    input  logic              in_converged,
    output logic              op_enableAccumCalc,
    output logic              op_allItersDoneFlag,
    output logic              op_busy,
    output logic [CNT_W-1:0]  op_iterIdx,
    output logic [BANK_W-1:0] op_writeBank,
    output logic [BANK_W-1:0] op_readBank,
    output logic              op_convergedExit,
    output logic              op_timeout
);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  iters_q, iters_d;
    logic [CNT_W-1:0]  iterIdx_q, iterIdx_d;
    logic [BANK_W-1:0] writeBank_q, writeBank_d;
    logic [BANK_W-1:0] readBank_q, readBank_d;
    logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;
    logic              enable_q, enable_d;
    logic              doneFlag_q, doneFlag_d;
    logic              busy_q, busy_d;
    logic              convExit_q, convExit_d;
    logic              timeout_q, timeout_d;

    logic wdClear, wdEnable, wdExpire;

    assign wdEnable = (state_q == ST_RUN);
    assign wdClear  = (state_q != ST_RUN) || in_accumCalcDoneFlag;

    iter_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (wdClear),
        .enable_i (wdEnable),
        .expire_o (wdExpire)
    );

    always_comb begin
        state_d     = state_q;
        iters_d     = iters_q;
        iterIdx_d   = iterIdx_q;
        writeBank_d = writeBank_q;
        readBank_d  = readBank_q;
        gapCnt_d    = gapCnt_q;
        enable_d    = enable_q;
        doneFlag_d  = 1'b0;
        busy_d      = busy_q;
        convExit_d  = convExit_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_start && !in_abort) begin
                    iters_d    = (in_iters == '0) ? CNT_W'(DEFAULT_ITERS) : in_iters;
                    iterIdx_d  = '0;
                    convExit_d = 1'b0;
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
                    enable_d   = 1'b1;
                    state_d    = ST_RUN;
                end
            end

            ST_RUN: begin
                if (in_abort) begin
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (in_accumCalcDoneFlag) begin
                    iterIdx_d   = iterIdx_q + CNT_W'(1);
                    writeBank_d = BANK_W'(bankInc(32'(writeBank_q), NUM_BANKS));
                    readBank_d  = writeBank_q;
                    enable_d    = 1'b0;
                    if (in_converged) begin
                        convExit_d = 1'b1;
                        state_d    = ST_DONE;
                    end else if (iterIdx_d == iters_q) begin
                        state_d = ST_DONE;
                    end else begin
                        gapCnt_d = GAP_W'(GAP_CYCLES);
                        state_d  = ST_GAP;
                    end
                end else if (wdExpire) begin
                    timeout_d = 1'b1;
                    enable_d  = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            ST_GAP: begin
                if (in_abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (gapCnt_q == GAP_W'(1)) begin
                    enable_d = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    gapCnt_d = gapCnt_q - GAP_W'(1);
                end
            end

            ST_DONE: begin
                // The completion pulse lands on the same edge busy drops, unless aborted here.
                busy_d     = 1'b0;
                doneFlag_d = !in_abort;
                state_d    = ST_IDLE;
            end

            default: begin
                enable_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            iters_q     <= '0;
            iterIdx_q   <= '0;
            writeBank_q <= '0;
            readBank_q  <= BANK_W'(NUM_BANKS - 1);
            gapCnt_q    <= '0;
            enable_q    <= 1'b0;
            doneFlag_q  <= 1'b0;
            busy_q      <= 1'b0;
            convExit_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            iters_q     <= iters_d;
            iterIdx_q   <= iterIdx_d;
            writeBank_q <= writeBank_d;
            readBank_q  <= readBank_d;
            gapCnt_q    <= gapCnt_d;
            enable_q    <= enable_d;
            doneFlag_q  <= doneFlag_d;
            busy_q      <= busy_d;
            convExit_q  <= convExit_d;
            timeout_q   <= timeout_d;
        end
    end

    assign op_enableAccumCalc  = enable_q;
    assign op_allItersDoneFlag = doneFlag_q;
    assign op_busy             = busy_q;
    assign op_iterIdx          = iterIdx_q;
    assign op_writeBank        = writeBank_q;
    assign op_readBank         = readBank_q;
    assign op_convergedExit    = convExit_q;
    assign op_timeout          = timeout_q;

endmodule

// File: tb/tb_iter_sequencer.sv
// Self-checking bench for iter_sequencer using a pass-count model of iterations and bank rotation.
module tb_iter_sequencer;

    localparam int CNT_W     = 6;
    localparam int DEF_ITERS = 30;
    localparam int GAP       = 3;
    localparam int NB        = 3;
    localparam int TW        = 5;
    localparam int BW        = $clog2(NB);
    localparam int WD_LIMIT  = (1 << TW) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_start, in_abort, in_done, in_conv;
    logic [CNT_W-1:0] in_iters;
    logic             enable, allDone, busy, convExit, timeout;
    logic [CNT_W-1:0] iterIdx;
    logic [BW-1:0]    writeBank, readBank;

    int checks    = 0;
    int passed    = 0;
    int rotations = 0;
    int flagCount = 0;

    always #5 clock = ~clock;

    always @(negedge clock) if (allDone === 1'b1) flagCount++;

    iter_sequencer #(
        .CNT_W         (CNT_W),
        .DEFAULT_ITERS (DEF_ITERS),
        .GAP_CYCLES    (GAP),
        .NUM_BANKS     (NB),
        .TIMEOUT_W     (TW)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .in_start             (in_start),
        .in_iters             (in_iters),
        .in_abort             (in_abort),
        .in_accumCalcDoneFlag (in_done),
        .in_converged         (in_conv),
        .op_enableAccumCalc   (enable),
        .op_allItersDoneFlag  (allDone),
        .op_busy              (busy),
        .op_iterIdx           (iterIdx),
        .op_writeBank         (writeBank),
        .op_readBank          (readBank),
        .op_convergedExit     (convExit),
        .op_timeout           (timeout)
    );

    function automatic logic [BW-1:0] expWrite();
        return BW'(rotations % NB);
    endfunction

    function automatic logic [BW-1:0] expRead();
        return BW'((rotations + NB - 1) % NB);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic startSeq(input int iters);
        in_start = 1'b1;
        in_iters = CNT_W'(iters);
        tick();
        in_start = 1'b0;
    endtask

    task automatic pulseDone(input bit conv);
        in_done = 1'b1;
        in_conv = conv;
        tick();
        in_done = 1'b0;
        in_conv = 1'b0;
    endtask

    // Counts enable-low cycles, assuming the current cycle is already low.
    task automatic measureGap(output int n);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (enable === 1'b1) break;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_start = 1'b0; in_abort = 1'b0; in_done = 1'b0; in_conv = 1'b0; in_iters = '0;
        repeat (3) tick();
        checks++; if (enable !== 1'b0) $display("[TB] FAIL reset_enable: got %b want 0", enable); else passed++;
        checks++; if (allDone !== 1'b0) $display("[TB] FAIL reset_flag: got %b want 0", allDone); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (iterIdx !== '0) $display("[TB] FAIL reset_idx: got %0d want 0", iterIdx); else passed++;
        checks++; if (writeBank !== '0) $display("[TB] FAIL reset_wbank: got %0d want 0", writeBank); else passed++;
        checks++; if (readBank !== BW'(NB - 1)) $display("[TB] FAIL reset_rbank: got %0d want %0d", readBank, NB - 1); else passed++;
        checks++; if (convExit !== 1'b0 || timeout !== 1'b0) $display("[TB] FAIL reset_sticky: got %b%b want 00", convExit, timeout); else passed++;
        reset = 1'b0;
        rotations = 0;
        tick();
    endtask

    task automatic test_default_iters();
        int f0, lat, gapLen;
        f0 = flagCount;
        startSeq(0);
        checks++; if (busy !== 1'b1 || enable !== 1'b1) $display("[TB] FAIL start_latency: got busy=%b en=%b want 1 1", busy, enable); else passed++;
        for (int p = 1; p <= DEF_ITERS; p++) begin
            lat = $urandom_range(1, 20);
            repeat (lat - 1) tick();
            checks++; if (enable !== 1'b1) $display("[TB] FAIL t1_enable_run p%0d: got %b want 1", p, enable); else passed++;
            pulseDone(1'b0);
            rotations++;
            checks++; if (iterIdx !== CNT_W'(p)) $display("[TB] FAIL t1_idx: got %0d want %0d", iterIdx, p); else passed++;
            checks++; if (writeBank !== expWrite() || readBank !== expRead())
                $display("[TB] FAIL t1_banks p%0d: got w%0d r%0d want w%0d r%0d", p, writeBank, readBank, expWrite(), expRead()); else passed++;
            checks++; if (enable !== 1'b0) $display("[TB] FAIL t1_enable_drop p%0d: got %b want 0", p, enable); else passed++;
            if (p < DEF_ITERS) begin
                measureGap(gapLen);
                checks++; if (gapLen != GAP) $display("[TB] FAIL t1_gap p%0d: got %0d want %0d", p, gapLen, GAP); else passed++;
            end
        end
        checks++; if (busy !== 1'b1 || allDone !== 1'b0) $display("[TB] FAIL t1_done_state: got busy=%b flag=%b want 1 0", busy, allDone); else passed++;
        tick();
        checks++; if (allDone !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL t1_flag: got flag=%b busy=%b want 1 0", allDone, busy); else passed++;
        tick();
        checks++; if (flagCount - f0 != 1) $display("[TB] FAIL t1_flag_count: got %0d want 1", flagCount - f0); else passed++;
        checks++; if (iterIdx !== CNT_W'(DEF_ITERS)) $display("[TB] FAIL t1_final_idx: got %0d want %0d", iterIdx, DEF_ITERS); else passed++;
    endtask

    task automatic test_converged();
        int iters, convAt, lat, gapLen, f0;
        iters  = $urandom_range(6, 20);
        convAt = $urandom_range(2, 5);
        f0 = flagCount;
        startSeq(iters);
        // Convergence without a done pulse must not be sampled.
        in_conv = 1'b1; tick(); in_conv = 1'b0;
        for (int p = 1; p <= convAt; p++) begin
            lat = $urandom_range(1, 8);
            repeat (lat - 1) tick();
            pulseDone(p == convAt);
            rotations++;
            if (p < convAt) begin
                checks++; if (convExit !== 1'b0) $display("[TB] FAIL t3_conv_early p%0d: got %b want 0", p, convExit); else passed++;
                measureGap(gapLen);
            end
        end
        checks++; if (iterIdx !== CNT_W'(convAt)) $display("[TB] FAIL t3_idx: got %0d want %0d", iterIdx, convAt); else passed++;
        checks++; if (convExit !== 1'b1 || enable !== 1'b0) $display("[TB] FAIL t3_exit: got conv=%b en=%b want 1 0", convExit, enable); else passed++;
        checks++; if (writeBank !== expWrite()) $display("[TB] FAIL t3_wbank: got %0d want %0d", writeBank, expWrite()); else passed++;
        tick();
        checks++; if (allDone !== 1'b1) $display("[TB] FAIL t3_flag: got %b want 1", allDone); else passed++;
        tick();
        checks++; if (busy !== 1'b0 || convExit !== 1'b1 || flagCount - f0 != 1)
            $display("[TB] FAIL t3_after: got busy=%b conv=%b flags=%0d want 0 1 1", busy, convExit, flagCount - f0); else passed++;
    endtask

    task automatic test_timeout();
        int n, f0;
        f0 = flagCount;
        startSeq(5);
        checks++; if (convExit !== 1'b0) $display("[TB] FAIL t4_conv_clear: got %b want 0", convExit); else passed++;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (timeout === 1'b1) break;
        end
        checks++; if (n != WD_LIMIT) $display("[TB] FAIL t4_timeout_cycles: got %0d want %0d", n, WD_LIMIT); else passed++;
        checks++; if (busy !== 1'b0 || enable !== 1'b0) $display("[TB] FAIL t4_idle: got busy=%b en=%b want 0 0", busy, enable); else passed++;
        checks++; if (iterIdx !== '0 || writeBank !== expWrite() || readBank !== expRead())
            $display("[TB] FAIL t4_hold: got idx%0d w%0d r%0d want idx0 w%0d r%0d", iterIdx, writeBank, readBank, expWrite(), expRead()); else passed++;
        tick();
        checks++; if (flagCount != f0) $display("[TB] FAIL t4_no_flag: got %0d want 0", flagCount - f0); else passed++;
        // Done on the saturating cycle takes priority over the watchdog.
        startSeq(5);
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL t4_timeout_clear: got %b want 0", timeout); else passed++;
        repeat (WD_LIMIT - 1) tick();
        pulseDone(1'b0);
        rotations++;
        checks++; if (timeout !== 1'b0 || iterIdx !== CNT_W'(1)) $display("[TB] FAIL t4_done_wins: got to=%b idx=%0d want 0 1", timeout, iterIdx); else passed++;
        checks++; if (writeBank !== expWrite()) $display("[TB] FAIL t4_done_wins_bank: got %0d want %0d", writeBank, expWrite()); else passed++;
        in_abort = 1'b1; tick(); in_abort = 1'b0;
        checks++; if (busy !== 1'b0 || enable !== 1'b0 || iterIdx !== CNT_W'(1))
            $display("[TB] FAIL t4_abort_gap: got busy=%b en=%b idx=%0d want 0 0 1", busy, enable, iterIdx); else passed++;
        repeat (GAP + 1) tick();
        checks++; if (enable !== 1'b0) $display("[TB] FAIL t4_abort_gap_stay: got %b want 0", enable); else passed++;
    endtask

    task automatic test_abort();
        int gapLen, f0;
        f0 = flagCount;
        startSeq(8);
        repeat (2) tick();
        pulseDone(1'b0);
        rotations++;
        measureGap(gapLen);
        repeat (2) tick();
        in_abort = 1'b1; in_done = 1'b1; tick(); in_abort = 1'b0; in_done = 1'b0;
        checks++; if (iterIdx !== CNT_W'(1)) $display("[TB] FAIL t5_abort_idx: got %0d want 1", iterIdx); else passed++;
        checks++; if (writeBank !== expWrite() || readBank !== expRead())
            $display("[TB] FAIL t5_abort_banks: got w%0d r%0d want w%0d r%0d", writeBank, readBank, expWrite(), expRead()); else passed++;
        checks++; if (busy !== 1'b0 || enable !== 1'b0) $display("[TB] FAIL t5_abort_idle: got busy=%b en=%b want 0 0", busy, enable); else passed++;
        in_start = 1'b1; in_abort = 1'b1; in_iters = 6'd4; tick(); in_start = 1'b0; in_abort = 1'b0;
        checks++; if (busy !== 1'b0 || enable !== 1'b0) $display("[TB] FAIL t5_start_abort: got busy=%b en=%b want 0 0", busy, enable); else passed++;
        // Abort while in DONE suppresses the completion pulse.
        startSeq(1);
        tick();
        pulseDone(1'b0);
        rotations++;
        in_abort = 1'b1; tick(); in_abort = 1'b0;
        tick();
        checks++; if (flagCount != f0 || busy !== 1'b0) $display("[TB] FAIL t5_abort_done: got flags=%0d busy=%b want 0 0", flagCount - f0, busy); else passed++;
        startSeq(4);
        repeat (3) tick();
        reset = 1'b1; in_done = 1'b1; in_start = 1'b1; tick();
        reset = 1'b0; in_done = 1'b0; in_start = 1'b0;
        rotations = 0;
        checks++; if (busy !== 1'b0 || enable !== 1'b0 || iterIdx !== '0)
            $display("[TB] FAIL t5_reset_run: got busy=%b en=%b idx=%0d want 0 0 0", busy, enable, iterIdx); else passed++;
        checks++; if (writeBank !== '0 || readBank !== BW'(NB - 1))
            $display("[TB] FAIL t5_reset_banks: got w%0d r%0d want w0 r%0d", writeBank, readBank, NB - 1); else passed++;
    endtask

    task automatic test_back_to_back();
        int gapLen, f0, lat;
        f0 = flagCount;
        startSeq(4);
        repeat (2) tick();
        in_start = 1'b1; in_iters = 6'd2; tick(); in_start = 1'b0;
        pulseDone(1'b0);
        rotations++;
        in_done = 1'b1; tick(); in_done = 1'b0;
        measureGap(gapLen);
        checks++; if (gapLen + 1 != GAP) $display("[TB] FAIL t6_gap_done: got %0d want %0d", gapLen + 1, GAP); else passed++;
        checks++; if (iterIdx !== CNT_W'(1) || writeBank !== expWrite())
            $display("[TB] FAIL t6_gap_ignore: got idx%0d w%0d want idx1 w%0d", iterIdx, writeBank, expWrite()); else passed++;
        for (int p = 2; p <= 4; p++) begin
            lat = $urandom_range(1, 6);
            repeat (lat - 1) tick();
            pulseDone(1'b0);
            rotations++;
            if (p < 4) measureGap(gapLen);
        end
        checks++; if (iterIdx !== CNT_W'(4)) $display("[TB] FAIL t6_restart_ignored: got %0d want 4", iterIdx); else passed++;
        repeat (2) tick();
        pulseDone(1'b0);
        tick();
        checks++; if (iterIdx !== CNT_W'(4) || writeBank !== expWrite() || readBank !== expRead())
            $display("[TB] FAIL t6_idle_done: got idx%0d w%0d r%0d want idx4 w%0d r%0d", iterIdx, writeBank, readBank, expWrite(), expRead()); else passed++;
        checks++; if (busy !== 1'b0 || enable !== 1'b0 || flagCount - f0 != 1)
            $display("[TB] FAIL t6_idle_state: got busy=%b en=%b flags=%0d want 0 0 1", busy, enable, flagCount - f0); else passed++;
    endtask

    initial begin
        test_reset();
        test_default_iters();
        test_converged();
        test_timeout();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no completion want completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
